// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: a Moore FSM that sequences fetch,
// decode, memory, ALU, branch and jump steps. It also keeps a retired-
// instruction counter and a sticky illegal-opcode flag.
// Optional build macro MEM_TIMEOUT_EN adds a memory-wait watchdog. The
// watchdog traps when a FETCH/MEMRD/MEMWR wait lasts too long.
module multicycle_control #(
  parameter int ALUOP_W = 2,
  parameter int CNT_W   = 32,
  parameter int TMO_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  output logic               IorD,
  output logic               IRWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               BranchNe,
  output logic [1:0]         PCSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ExtOp,
  output logic               JalEn,
  output logic               LuiEn,
  output logic [3:0]         state_o,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    IEXEC  = 4'd9,
    IWB    = 4'd10,
    JUMP   = 4'd11,
    TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);  // LW/SW/ADDI
  localparam logic [ALUOP_W-1:0] ALU_BR    = ALUOP_W'(1);  // BEQ/BNE
  localparam logic [ALUOP_W-1:0] ALU_RTYPE = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_LOGIC = ALUOP_W'(3);  // ANDI/ORI/XORI

  state_t state, nextState;
  logic   isLogicImm, isLui, tmoHit;

  assign isLogicImm = (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
  assign isLui      = (opcode == OP_LUI);
  assign state_o    = state;

`ifdef MEM_TIMEOUT_EN
  logic [TMO_W-1:0] tmoCnt;

  // Trap on the wait cycle that would carry the counter to its all-ones value.
  assign tmoHit = !mem_ready && (tmoCnt == {{(TMO_W-1){1'b1}}, 1'b0});

  // Wait counter: counts while a memory state holds, cleared otherwise so
  // every entry into FETCH/MEMRD/MEMWR starts from zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmoCnt <= '0;
    end else if ((state == FETCH || state == MEMRD || state == MEMWR) && !mem_ready) begin
      tmoCnt <= tmoCnt + TMO_W'(1);
    end else begin
      tmoCnt <= '0;
    end
  end
`else
  assign tmoHit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= FETCH;
    else        state <= nextState;
  end

  // Retired counter: any step back into FETCH completes an instruction.
  always_ff @(posedge clk) begin
    if (!rst_n) retired <= '0;
    else if (state != FETCH && nextState == FETCH) retired <= retired + CNT_W'(1);
  end

  // Sticky illegal flag, raised as the FSM enters TRAP.
  always_ff @(posedge clk) begin
    if (!rst_n) illegal <= 1'b0;
    else if (nextState == TRAP) illegal <= 1'b1;
  end

  // Next-state logic.
  always_comb begin
    nextState = state;
    unique case (state)
      FETCH: begin
        if (mem_ready)   nextState = DECODE;
        else if (tmoHit) nextState = TRAP;
      end
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW:                              nextState = MEMADR;
          OP_RTYPE:                                  nextState = EXEC;
          OP_BEQ, OP_BNE:                            nextState = BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: nextState = IEXEC;
          OP_J, OP_JAL:                              nextState = JUMP;
          default:                                   nextState = TRAP;
        endcase
      end
      MEMADR: nextState = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD: begin
        if (mem_ready)   nextState = MEMWB;
        else if (tmoHit) nextState = TRAP;
      end
      MEMWB: nextState = FETCH;
      MEMWR: begin
        if (mem_ready)   nextState = FETCH;
        else if (tmoHit) nextState = TRAP;
      end
      EXEC:   nextState = (funct == FN_JR) ? FETCH : RWB;
      RWB:    nextState = FETCH;
      BRANCH: nextState = FETCH;
      IEXEC:  nextState = IWB;
      IWB:    nextState = FETCH;
      JUMP:   nextState = FETCH;
      TRAP:   nextState = TRAP;
      default: nextState = TRAP;
    endcase
  end

  // Moore output decode.
  always_comb begin
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNe    = 1'b0;
    PCSrc       = 2'd0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'd0;
    ALUOp       = ALU_ADD;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ExtOp       = 1'b1;
    JalEn       = 1'b0;
    LuiEn       = 1'b0;
    unique case (state)
      FETCH: begin
        MemRead = 1'b1;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        ALUSrcB = 2'd1;
      end
      DECODE: ALUSrcB = 2'd3;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
      end
      MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_RTYPE;
        if (funct == FN_JR) begin
          PCWrite = 1'b1;
          PCSrc   = 2'd3;
        end
      end
      RWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALU_BR;
        PCWriteCond = 1'b1;
        PCSrc       = 2'd1;
        BranchNe    = (opcode == OP_BNE);
      end
      IEXEC, IWB: begin
        if (state == IEXEC) begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'd2;
        end else begin
          RegWrite = 1'b1;
        end
        if (isLogicImm) begin
          ExtOp = 1'b0;
          ALUOp = ALU_LOGIC;
        end
        LuiEn = isLui;
      end
      JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = 2'd2;
        if (opcode == OP_JAL) begin
          RegWrite = 1'b1;
          JalEn    = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class
// through the FSM and checks state, strobes, retired and illegal.
module tb_multicycle_control;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BAD   = 6'h3F;

  logic       clk = 1'b0;
  logic       rst_n, mem_ready;
  logic [5:0] opcode, funct;
  logic       IorD, IRWrite, MemRead, MemWrite, PCWrite, PCWriteCond, BranchNe;
  logic [1:0] PCSrc, ALUSrcB, ALUOp;
  logic       ALUSrcA, RegDst, MemtoReg, RegWrite, ExtOp, JalEn, LuiEn, illegal;
  logic [3:0] state_o, retired;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  multicycle_control #(.ALUOP_W(2), .CNT_W(4), .TMO_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .IorD(IorD), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe),
    .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ExtOp(ExtOp),
    .JalEn(JalEn), .LuiEn(LuiEn), .state_o(state_o), .illegal(illegal),
    .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; opcode = OP_RTYPE; funct = 6'h00; mem_ready = 1'b1;
    tick();
    check("rst_state", state_o, 0);
    check("rst_retired", retired, 0);
    check("rst_illegal", illegal, 0);
    check("fetch_memread", MemRead, 1);
    check("fetch_irwrite", IRWrite, 1);
    check("fetch_pcwrite", PCWrite, 1);
    check("fetch_alusrcb", ALUSrcB, 1);

    // LW with memory always ready: 0,1,2,3,4,0
    rst_n = 1'b1; opcode = OP_LW;
    tick();
    check("lw_decode", state_o, 1);
    check("decode_alusrcb", ALUSrcB, 3);
    check("lw_dec_regwrite", RegWrite, 0);
    tick();
    check("lw_memadr", state_o, 2);
    check("memadr_alusrca", ALUSrcA, 1);
    check("memadr_alusrcb", ALUSrcB, 2);
    check("lw_adr_regwrite", RegWrite, 0);
    tick();
    check("lw_memrd", state_o, 3);
    check("memrd_iord", IorD, 1);
    check("memrd_memread", MemRead, 1);
    check("lw_rd_regwrite", RegWrite, 0);
    tick();
    check("lw_memwb", state_o, 4);
    check("memwb_regwrite", RegWrite, 1);
    check("memwb_memtoreg", MemtoReg, 1);
    check("lw_wb_retired", retired, 0);
    tick();
    check("lw_fetch", state_o, 0);
    check("lw_retired", retired, 1);
    check("lw_fetch_regwrite", RegWrite, 0);

    // SW with five not-ready cycles in MEMWR; mem_ready ignored in DECODE/MEMADR
    opcode = OP_SW;
    tick();
    check("sw_decode", state_o, 1);
    mem_ready = 1'b0;
    tick();
    check("sw_memadr", state_o, 2);
    tick();
    for (int i = 0; i < 6; i++) begin
      check("sw_memwr_state", state_o, 5);
      check("sw_memwrite", MemWrite, 1);
      check("sw_iord", IorD, 1);
      check("sw_wait_retired", retired, 1);
      if (i == 5) mem_ready = 1'b1;
      tick();
    end
    check("sw_fetch", state_o, 0);
    check("sw_retired", retired, 2);

    // FETCH waits while memory is not ready
    mem_ready = 1'b0;
    tick();
    tick();
    check("fwait_state", state_o, 0);
    check("fwait_irwrite", IRWrite, 0);
    check("fwait_pcwrite", PCWrite, 0);
    check("fwait_memread", MemRead, 1);
    mem_ready = 1'b1;

    // JR
    opcode = OP_RTYPE; funct = 6'h08;
    tick(); tick();
    check("jr_exec", state_o, 6);
    check("jr_pcwrite", PCWrite, 1);
    check("jr_pcsrc", PCSrc, 3);
    check("jr_aluop", ALUOp, 2);
    check("jr_regwrite", RegWrite, 0);
    tick();
    check("jr_fetch", state_o, 0);
    check("jr_retired", retired, 3);
    check("jr_fetch_regwrite", RegWrite, 0);

    // R-type ADD
    funct = 6'h20;
    tick(); tick();
    check("add_exec", state_o, 6);
    check("add_pcwrite", PCWrite, 0);
    tick();
    check("add_rwb", state_o, 7);
    check("rwb_regdst", RegDst, 1);
    check("rwb_regwrite", RegWrite, 1);
    tick();
    check("add_retired", retired, 4);

    // ORI
    opcode = OP_ORI;
    tick(); tick();
    check("ori_iexec", state_o, 9);
    check("ori_iexec_extop", ExtOp, 0);
    check("ori_iexec_aluop", ALUOp, 3);
    check("ori_iexec_alusrcb", ALUSrcB, 2);
    tick();
    check("ori_iwb", state_o, 10);
    check("ori_iwb_regwrite", RegWrite, 1);
    check("ori_iwb_extop", ExtOp, 0);
    check("ori_iwb_aluop", ALUOp, 3);
    tick();
    check("ori_retired", retired, 5);

    // LUI
    opcode = OP_LUI;
    tick(); tick();
    check("lui_iexec_luien", LuiEn, 1);
    check("lui_iexec_extop", ExtOp, 1);
    tick();
    check("lui_iwb_luien", LuiEn, 1);
    tick();
    check("lui_retired", retired, 6);

    // BNE then BEQ
    opcode = OP_BNE;
    tick(); tick();
    check("bne_branch", state_o, 8);
    check("bne_branchne", BranchNe, 1);
    check("bne_pcwritecond", PCWriteCond, 1);
    check("bne_pcsrc", PCSrc, 1);
    check("bne_aluop", ALUOp, 1);
    tick();
    check("bne_retired", retired, 7);
    opcode = OP_BEQ;
    tick(); tick();
    check("beq_branch", state_o, 8);
    check("beq_branchne", BranchNe, 0);
    tick();
    check("beq_retired", retired, 8);

    // JAL then J
    opcode = OP_JAL;
    tick(); tick();
    check("jal_jump", state_o, 11);
    check("jal_pcwrite", PCWrite, 1);
    check("jal_pcsrc", PCSrc, 2);
    check("jal_regwrite", RegWrite, 1);
    check("jal_jalen", JalEn, 1);
    tick();
    check("jal_retired", retired, 9);
    opcode = OP_J;
    tick(); tick();
    check("j_jump", state_o, 11);
    check("j_jalen", JalEn, 0);
    check("j_regwrite", RegWrite, 0);
    tick();
    check("j_retired", retired, 10);

    // ADDI
    opcode = OP_ADDI;
    tick(); tick();
    check("addi_iexec", state_o, 9);
    check("addi_extop", ExtOp, 1);
    check("addi_aluop", ALUOp, 0);
    tick(); tick();
    check("addi_retired", retired, 11);

    // Reset during a MEMRD wait abandons the load
    opcode = OP_LW;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    tick();
    check("rstmid_memrd", state_o, 3);
    rst_n = 1'b0;
    tick();
    check("rstmid_state", state_o, 0);
    check("rstmid_retired", retired, 0);
    rst_n = 1'b1; mem_ready = 1'b1;

    // Counter wrap at 2^CNT_W (CNT_W = 4): 16 jumps take it back to 0
    opcode = OP_J;
    for (int i = 0; i < 15; i++) begin
      tick(); tick(); tick();
    end
    check("wrap_pre", retired, 15);
    tick(); tick(); tick();
    check("wrap_zero", retired, 0);

    // Illegal opcode traps and holds regardless of mem_ready
    opcode = OP_BAD;
    tick(); tick();
    check("trap_state", state_o, 12);
    check("trap_illegal", illegal, 1);
    for (int i = 0; i < 10; i++) begin
      mem_ready = logic'(i % 2);
      tick();
      check("trap_hold", state_o, 12);
      check("trap_hold_illegal", illegal, 1);
      check("trap_memread", MemRead, 0);
      check("trap_pcwrite", PCWrite, 0);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("trap_rst_state", state_o, 0);
    check("trap_rst_illegal", illegal, 0);

    // Stalled FETCH: traps after 7 cycles with the watchdog, waits forever without
    opcode = OP_LW; mem_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
`ifdef MEM_TIMEOUT_EN
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("tmo_waiting", state_o, 0);
    end
    tick();
    check("tmo_trap", state_o, 12);
    check("tmo_illegal", illegal, 1);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      check("nowd_waiting", state_o, 0);
    end
    check("nowd_illegal", illegal, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter ALUOP_W, default 2, ALUOp width.
REQ-002 Parameter CNT_W, default 32, retired-instruction counter width.
REQ-003 Parameter TMO_W, default 8, memory-timeout counter width.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset; synchronous, active-low.
REQ-006 opcode  in  6  instruction[31:26], sampled from the instruction register.
REQ-007 funct  in  6  instruction[5:0].
REQ-008 mem_ready  in  1  memory access-complete handshake.
REQ-009 IorD, IRWrite, MemRead, MemWrite, PCWrite, PCWriteCond, BranchNe  out  1 each  datapath strobes.
REQ-010 PCSrc  out  2  PC source: 0 = ALU, 1 = ALUOut, 2 = jump target, 3 = rs (JR).
REQ-011 ALUSrcA  out  1  ALU A operand: 0 = PC, 1 = rs.
REQ-012 ALUSrcB  out  2  ALU B operand: 0 = rt, 1 = constant 4, 2 = ext imm, 3 = ext imm<<2.
REQ-013 ALUOp  out  ALUOP_W  ALU operation, using the project defines encodings (LW/SW/ADDI, BEQ/BNE, RTYPE, ANDI/ORI/XORI).
REQ-014 RegDst, MemtoReg, RegWrite, ExtOp, JalEn, LuiEn  out  1 each  writeback and extension controls.
REQ-015 state_o  out  4  current state encoding.
REQ-016 illegal  out  1  sticky flag: unsupported opcode seen.
REQ-017 retired  out  CNT_W  count of completed instructions.

Function
REQ-018 States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, IEXEC=9, IWB=10, JUMP=11, TRAP=12.
REQ-019 Outputs are Moore, decoded from state only; every strobe defaults to 0, ExtOp defaults to 1, and ALUOp defaults to LW/SW/ADDI.
REQ-020 FETCH: MemRead=1, IRWrite=1, ALUSrcB=1.
  - PCWrite and IRWrite are asserted only while mem_ready=1.
  - Remains in FETCH until mem_ready=1, then goes to DECODE.
REQ-021 DECODE: ALUSrcB=3, then branches on opcode.
  - LW/SW -> MEMADR; R-type -> EXEC; BEQ/BNE -> BRANCH; ADDI/ANDI/ORI/XORI/LUI -> IEXEC; J/JAL -> JUMP.
  - Any other opcode -> TRAP.
REQ-022 MEMADR: ALUSrcA=1, ALUSrcB=2; LW -> MEMRD, SW -> MEMWR.
REQ-023 MEMRD: IorD=1, MemRead=1; holds until mem_ready=1, then -> MEMWB.
REQ-024 MEMWB: RegWrite=1, MemtoReg=1; -> FETCH.
REQ-025 MEMWR: IorD=1, MemWrite=1; holds until mem_ready=1, then -> FETCH.
REQ-026 EXEC: ALUSrcA=1, ALUOp=RTYPE.
  - If funct=0x08 (JR): PCWrite=1, PCSrc=3, then -> FETCH without writeback.
  - Otherwise -> RWB.
REQ-027 RWB: RegDst=1, RegWrite=1; -> FETCH.
REQ-028 BRANCH: ALUSrcA=1, ALUOp=BEQ/BNE, PCWriteCond=1, PCSrc=1, BranchNe=(opcode==BNE); -> FETCH.
REQ-029 IEXEC: ALUSrcA=1, ALUSrcB=2; -> IWB.
  - ANDI/ORI/XORI: ExtOp=0, ALUOp=ANDI/ORI/XORI.
  - LUI: LuiEn=1.
REQ-030 IWB: RegWrite=1, same ExtOp/ALUOp/LuiEn as IEXEC; -> FETCH.
REQ-031 JUMP: PCWrite=1, PCSrc=2; for JAL also RegWrite=1, JalEn=1; -> FETCH.
REQ-032 TRAP: all strobes 0, illegal set to 1; remains in TRAP until reset.
REQ-033 retired increments by 1 on each transition into FETCH from MEMWB, MEMWR, RWB, EXEC(JR), BRANCH, IWB or JUMP; it wraps modulo 2^CNT_W.
REQ-034 Memory strobes hold their values for every wait cycle while mem_ready=0.
REQ-035 mem_ready is ignored in all states other than FETCH, MEMRD and MEMWR.

Reset
REQ-036 While rst_n=0 at a clk edge: state=FETCH, retired=0, illegal=0, timeout counter=0.
REQ-037 Reset asserted mid-instruction, including during a memory wait, abandons that instruction and does not increment retired.

Configuration
REQ-038 With MEM_TIMEOUT_EN defined:
  - A TMO_W counter clears on entry to FETCH, MEMRD and MEMWR, and increments each cycle the state waits with mem_ready=0.
  - When it reaches 2^TMO_W-1 with mem_ready still 0, the next state is TRAP and illegal=1.
REQ-039 Without MEM_TIMEOUT_EN: no timeout counter is built, and memory waits are unbounded.

Verification
REQ-040 LW (0x23), mem_ready=1 always -> states 0,1,2,3,4,0; RegWrite=1 only in MEMWB; retired 0->1.
REQ-041 SW (0x2B), mem_ready held 0 for 5 cycles in MEMWR -> MemWrite=1 and IorD=1 for all 6 cycles of MEMWR; retired increments once.
REQ-042 R-type funct 0x08 -> EXEC asserts PCWrite=1, PCSrc=3; next state FETCH; RegWrite never 1.
REQ-043 ORI (0x0D) -> ExtOp=0 and ALUOp=ANDI/ORI/XORI in IEXEC and IWB; BNE (0x05) -> BRANCH with BranchNe=1.
REQ-044 Opcode 0x3F -> TRAP, illegal=1, state held for 10 cycles; rst_n=0 for one edge -> FETCH, illegal=0.
REQ-045 MEM_TIMEOUT_EN with TMO_W=3, mem_ready=0 in FETCH -> TRAP 7 cycles after entering FETCH.
